// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Load/store initiator for a word-organised data memory with
//               sub-word read-modify-write and load extension.
//               Optional macro LSU_STRICT_ALIGN_EN flags misaligned/illegal
//               requests as errors instead of forcing alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Req_Valid,
    output logic                    Req_Ready,
    input  logic                    Req_Write,
    input  logic [1:0]              Req_Size,
    input  logic                    Req_Unsigned,
    input  logic [ADDR_WIDTH+1:0]   Req_Addr,
    input  logic [DATA_WIDTH-1:0]   Req_Wdata,
    output logic                    Rsp_Valid,
    output logic [DATA_WIDTH-1:0]   Rsp_Rdata,
    output logic                    Rsp_Error,
    output logic [ADDR_WIDTH-1:0]   Mem_Address,
    output logic [DATA_WIDTH-1:0]   Mem_Write_Data,
    output logic                    Mem_Write,
    output logic                    Mem_Read,
    input  logic [DATA_WIDTH-1:0]   Mem_Read_Data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t                r_state;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_off;
    logic [15:0]           r_wdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_mem_write;
    logic                  r_mem_read;

    logic                  w_req_word;
    logic                  w_req_err;
    logic                  w_lat_byte;
    logic                  w_lat_half;
    logic [1:0]            w_lane;
    logic [4:0]            w_shift;
    logic [15:0]           w_half;
    logic [7:0]            w_byte;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_mask;
    logic [DATA_WIDTH-1:0] w_ins;
    logic [DATA_WIDTH-1:0] w_merged;

    // Size 11 falls into the word path unless strict checking rejects it.
    assign w_req_word = (Req_Size != c_SIZE_BYTE) && (Req_Size != c_SIZE_HALF);

`ifdef LSU_STRICT_ALIGN_EN
    assign w_req_err = (Req_Size == 2'b11)
                    || ((Req_Size == c_SIZE_HALF) && Req_Addr[0])
                    || ((Req_Size == c_SIZE_WORD) && (Req_Addr[1:0] != 2'b00));
`else
    assign w_req_err = 1'b0;
`endif

    // Lane selection forces alignment; in strict builds it is already aligned.
    assign w_lat_byte = (r_size == c_SIZE_BYTE);
    assign w_lat_half = (r_size == c_SIZE_HALF);
    assign w_lane     = w_lat_byte ? r_off : (w_lat_half ? {r_off[1], 1'b0} : 2'b00);
    assign w_shift    = {w_lane, 3'b000};
    assign w_half     = 16'(Mem_Read_Data >> w_shift);
    assign w_byte     = w_half[7:0];

    always_comb begin
        w_load = Mem_Read_Data;
        if (w_lat_byte) begin
            w_load = {{(DATA_WIDTH-8){~r_unsigned & w_byte[7]}}, w_byte};
        end else if (w_lat_half) begin
            w_load = {{(DATA_WIDTH-16){~r_unsigned & w_half[15]}}, w_half};
        end
    end

    assign w_mask   = w_lat_byte ? (DATA_WIDTH'(8'hFF) << w_shift)
                                 : (DATA_WIDTH'(16'hFFFF) << w_shift);
    assign w_ins    = w_lat_byte ? (DATA_WIDTH'(r_wdata[7:0]) << w_shift)
                                 : (DATA_WIDTH'(r_wdata) << w_shift);
    assign w_merged = (Mem_Read_Data & ~w_mask) | w_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (Req_Valid) begin
                        r_write    <= Req_Write;
                        r_size     <= Req_Size;
                        r_unsigned <= Req_Unsigned;
                        r_off      <= Req_Addr[1:0];
                        r_wdata    <= Req_Wdata[15:0];
                        r_mem_addr <= Req_Addr[ADDR_WIDTH+1:2];
                        if (w_req_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_error <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else if (Req_Write && w_req_word) begin
                            r_state     <= S_WR;
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= Req_Wdata;
                        end else begin
                            r_state    <= S_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (r_write) begin
                        r_state     <= S_WR;
                        r_mem_write <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load;
                    end
                end
                S_WR: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Req_Ready      = (r_state == S_IDLE);
    assign Rsp_Valid      = r_rsp_valid;
    assign Rsp_Rdata      = r_rsp_rdata;
    assign Rsp_Error      = r_rsp_error;
    assign Mem_Address    = r_mem_addr;
    assign Mem_Write_Data = r_mem_wdata;
    assign Mem_Write      = r_mem_write;
    assign Mem_Read       = r_mem_read;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed bench for lsu_mem_master with a word memory model
//               and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Unsigned;
    logic [9:0]  Req_Addr;
    logic [31:0] Req_Wdata;
    logic        Rsp_Valid;
    logic [31:0] Rsp_Rdata;
    logic        Rsp_Error;
    logic [7:0]  Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_Write;
    logic        Mem_Read;
    logic [31:0] Mem_Read_Data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_rd    = 0;
    int          n_wr    = 0;
    logic        both_seen = 1'b0;

    lsu_mem_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Write      (Req_Write),
        .Req_Size       (Req_Size),
        .Req_Unsigned   (Req_Unsigned),
        .Req_Addr       (Req_Addr),
        .Req_Wdata      (Req_Wdata),
        .Rsp_Valid      (Rsp_Valid),
        .Rsp_Rdata      (Rsp_Rdata),
        .Rsp_Error      (Rsp_Error),
        .Mem_Address    (Mem_Address),
        .Mem_Write_Data (Mem_Write_Data),
        .Mem_Write      (Mem_Write),
        .Mem_Read       (Mem_Read),
        .Mem_Read_Data  (Mem_Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, clocked write.
    assign Mem_Read_Data = mem[Mem_Address];
    always @(posedge clk) begin
        if (Mem_Write) begin
            mem[Mem_Address] <= Mem_Write_Data;
            n_wr <= n_wr + 1;
        end
        if (Mem_Read) n_rd <= n_rd + 1;
    end

    always @(negedge clk) if (Mem_Read && Mem_Write) both_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, ".ready"},  Req_Ready, 1'b1);
        chk1({tag, ".rvalid"}, Rsp_Valid, 1'b0);
        chk1({tag, ".rerr"},   Rsp_Error, 1'b0);
        chk1({tag, ".mrd"},    Mem_Read,  1'b0);
        chk1({tag, ".mwr"},    Mem_Write, 1'b0);
        chk({tag, ".rdata"},   Rsp_Rdata, 32'h0);
        chk({tag, ".maddr"},   32'(Mem_Address), 32'h0);
        chk({tag, ".mwdata"},  Mem_Write_Data, 32'h0);
    endtask

    // One request: drive, wait for the response, compare against scoreboard.
    task automatic issue(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [9:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat, input int exp_nrd, input int exp_nwr);
        rsp_t r;
        int   lat;
        int   rd0;
        int   wr0;
        @(negedge clk);
        chk1({tag, ".ready"}, Req_Ready, 1'b1);
        Req_Valid    = 1'b1;
        Req_Write    = wr;
        Req_Size     = sz;
        Req_Unsigned = uns;
        Req_Addr     = addr;
        Req_Wdata    = wd;
        sb.push_back('{exp_rdata, exp_err});
        rd0 = n_rd;
        wr0 = n_wr;
        @(posedge clk);
        #1 Req_Valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Rsp_Valid && lat < 8);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        r = sb.pop_front();
        chk({tag, ".rdata"}, Rsp_Rdata, r.rdata);
        chk1({tag, ".err"}, Rsp_Error, r.err);
        chk({tag, ".nreads"},  32'(n_rd - rd0), 32'(exp_nrd));
        chk({tag, ".nwrites"}, 32'(n_wr - wr0), 32'(exp_nwr));
    endtask

    initial begin
        rsp_t r;
        int   wr0;
        rst_n        = 1'b0;
        Req_Valid    = 1'b0;
        Req_Write    = 1'b0;
        Req_Size     = 2'b00;
        Req_Unsigned = 1'b0;
        Req_Addr     = '0;
        Req_Wdata    = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Word store, then check the memory image and address.
        issue("st_word", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1);
        chk("st_word.mem", mem[4], 32'hDEADBEEF);
        chk("st_word.maddr", 32'(Mem_Address), 32'h04);

        // Byte store read-modify-write.
        issue("pre_1122", 1'b1, 2'b10, 1'b0, 10'h010, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);
        issue("st_byte", 1'b1, 2'b00, 1'b0, 10'h012, 32'hFFFFFFA5, 32'h0, 1'b0, 3, 1, 1);
        chk("st_byte.mem", mem[4], 32'h11A53344);

        // Loads on 0x80F0FF7F.
        issue("pre_80f0", 1'b1, 2'b10, 1'b0, 10'h010, 32'h80F0FF7F, 32'h0, 1'b0, 2, 0, 1);
        issue("ld_sb_011", 1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 32'hFFFFFFFF, 1'b0, 2, 1, 0);
        issue("ld_ub_011", 1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 32'h000000FF, 1'b0, 2, 1, 0);
        issue("ld_sh_012", 1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 32'hFFFF80F0, 1'b0, 2, 1, 0);
        issue("ld_uh_010", 1'b0, 2'b01, 1'b1, 10'h010, 32'h0, 32'h0000FF7F, 1'b0, 2, 1, 0);
        issue("ld_sb_010", 1'b0, 2'b00, 1'b0, 10'h010, 32'h0, 32'h0000007F, 1'b0, 2, 1, 0);
        issue("ld_w_010",  1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h80F0FF7F, 1'b0, 2, 1, 0);

        // Misaligned / illegal requests.
`ifdef LSU_STRICT_ALIGN_EN
        issue("ld_sh_013", 1'b0, 2'b01, 1'b0, 10'h013, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        issue("ld_w_011",  1'b0, 2'b10, 1'b0, 10'h011, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        issue("st_sz11",   1'b1, 2'b11, 1'b0, 10'h010, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
        chk("err.mem", mem[4], 32'h80F0FF7F);
`else
        issue("ld_sh_013", 1'b0, 2'b01, 1'b0, 10'h013, 32'h0, 32'hFFFF80F0, 1'b0, 2, 1, 0);
        issue("ld_sz11",   1'b0, 2'b11, 1'b0, 10'h013, 32'h0, 32'h80F0FF7F, 1'b0, 2, 1, 0);
`endif

        // Halfword store into the upper lane.
        issue("st_half", 1'b1, 2'b01, 1'b0, 10'h012, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1);
        chk("st_half.mem", mem[4], 32'hBEEFFF7F);

        // Back-to-back loads with Req_Valid held high.
        @(negedge clk);
        chk1("b2b.ready_idle0", Req_Ready, 1'b1);
        Req_Valid    = 1'b1;
        Req_Write    = 1'b0;
        Req_Size     = 2'b00;
        Req_Unsigned = 1'b1;
        Req_Addr     = 10'h013;
        sb.push_back('{32'h000000BE, 1'b0});
        @(negedge clk);
        chk1("b2b.ready_rd", Req_Ready, 1'b0);
        Req_Size     = 2'b01;
        Req_Unsigned = 1'b0;
        Req_Addr     = 10'h010;
        sb.push_back('{32'hFFFFFF7F, 1'b0});
        @(negedge clk);
        chk1("b2b.ready_resp", Req_Ready, 1'b0);
        chk1("b2b.valid_a", Rsp_Valid, 1'b1);
        r = sb.pop_front();
        chk("b2b.rdata_a", Rsp_Rdata, r.rdata);
        @(negedge clk);
        chk1("b2b.ready_idle1", Req_Ready, 1'b1);
        chk1("b2b.valid_idle", Rsp_Valid, 1'b0);
        @(posedge clk);
        #1 Req_Valid = 1'b0;
        @(negedge clk);
        chk1("b2b.ready_rd_b", Req_Ready, 1'b0);
        chk1("b2b.mrd_b", Mem_Read, 1'b1);
        @(negedge clk);
        chk1("b2b.valid_b", Rsp_Valid, 1'b1);
        r = sb.pop_front();
        chk("b2b.rdata_b", Rsp_Rdata, r.rdata);

        // Reset during the RD cycle of a byte store.
        @(negedge clk);
        Req_Valid = 1'b1;
        Req_Write = 1'b1;
        Req_Size  = 2'b00;
        Req_Addr  = 10'h011;
        Req_Wdata = 32'h00000055;
        wr0 = n_wr;
        @(posedge clk);
        #1 Req_Valid = 1'b0;
        @(negedge clk);
        chk1("midrst.mrd", Mem_Read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk1("midrst.no_rsp", Rsp_Valid, 1'b0);
        chk("midrst.nwrites", 32'(n_wr - wr0), 32'h0);
        chk("midrst.mem", mem[4], 32'hBEEFFF7F);
        rst_n = 1'b1;
        issue("post_rst_ld", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'hBEEFFF7F, 1'b0, 2, 1, 0);

        chk1("rd_wr_exclusive", both_seen, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-organised data memory port (Address, Write_Data, Mem_Write, Mem_Read, Read_Data) on behalf of the CPU datapath.
- Accepts one byte, halfword or word request at a time over a valid/ready handshake.
- Performs read-modify-write for sub-word stores, and sign- or zero-extends loads.
- Returns a one-cycle response pulse per request.
- Sits between the execute/memory stage and the data memory; the memory has combinational read and clocked write.

Parameters:
- DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes).
- ADDR_WIDTH, 8, memory word-address width; the CPU byte address is ADDR_WIDTH+2 bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  block can accept a request; high only in IDLE.
- Req_Write  in  1  1=store, 0=load.
- Req_Size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- Req_Unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- Req_Addr  in  ADDR_WIDTH+2  byte address.
- Req_Wdata  in  DATA_WIDTH  store data, right-justified.
- Rsp_Valid  out  1  one-cycle completion pulse.
- Rsp_Rdata  out  DATA_WIDTH  load result; 0 for stores and errors.
- Rsp_Error  out  1  qualified by Rsp_Valid; misaligned or illegal request.
- Mem_Address  out  ADDR_WIDTH  word address = latched Req_Addr[ADDR_WIDTH+1:2].
- Mem_Write_Data  out  DATA_WIDTH  word written to memory.
- Mem_Write  out  1  memory write strobe.
- Mem_Read  out  1  memory read enable.
- Mem_Read_Data  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE and the request latches are cleared.
  - Rsp_Valid, Rsp_Error, Mem_Read, Mem_Write = 0.
  - Rsp_Rdata, Mem_Address, Mem_Write_Data = 0.
  - Req_Ready = 1 because the state is IDLE.
- Accept: on a rising edge with Req_Valid & Req_Ready, latch Write, Size, Unsigned, Addr and Wdata. Request inputs are don't-care at all other times.
- States: IDLE, RD, WR, RESP.
- Transitions out of IDLE:
  - Load: IDLE -> RD -> RESP -> IDLE.
  - Word store: IDLE -> WR -> RESP -> IDLE.
  - Byte/half store: IDLE -> RD -> WR -> RESP -> IDLE.
  - Error request: IDLE -> RESP -> IDLE. No Mem_Read/Mem_Write is issued.
- RD state:
  - Mem_Read=1 for exactly one cycle.
  - At the closing edge, Mem_Read_Data is captured: extracted for loads, held as the old word for the RMW merge.
- WR state:
  - Mem_Write=1 for exactly one cycle.
  - Mem_Write_Data is the full Wdata for words, or the old word with the addressed lanes replaced.
  - Mem_Write_Data = 0 outside WR.
  - Mem_Read and Mem_Write are never both high.
- Byte lanes are little-endian: byte offset k = Addr[1:0] maps to bits [8k+7:8k]; a halfword at offset 2h uses bits [16h+15:16h].
- Store data uses Req_Wdata[7:0] for byte stores and Req_Wdata[15:0] for halfword stores.
- Load extraction: shift the addressed lane to bit 0, then sign- or zero-extend to 32 bits according to the latched Unsigned bit.
- RESP state:
  - Rsp_Valid=1 for one cycle; Rsp_Rdata and Rsp_Error are valid in the same cycle.
  - Rsp_Rdata is 0 for stores and errors.
  - There is no response backpressure.
  - Rsp_Rdata holds its value until the next RESP.
- Latency, in cycles from the accept edge to the Rsp_Valid cycle: load 2, word store 2, sub-word store 3, error 1.
- Throughput: a new request can be accepted in the IDLE cycle after RESP. There is no pipelining.
- Reset mid-operation: the request is abandoned with no response. If rst_n falls before the WR closing edge, no memory write occurs.
- Mem_Address holds the latched word address from accept until the next accept. Addresses wrap modulo 2^ADDR_WIDTH words because upper bits are truncated.

Optional Feature:
- Macro: LSU_STRICT_ALIGN_EN.
- Defined:
  - A halfword with Addr[0]=1, a word with Addr[1:0]!=0, or Size=11 takes the error path: Rsp_Error=1 and no memory access.
- Undefined:
  - Alignment is forced: halfword offset = Addr[1], word ignores Addr[1:0].
  - Size=11 is treated as a word.
  - Rsp_Error is tied to 0.

Test Plan:
- Reset, then a word store 0xDEADBEEF at byte address 0x010 -> Mem_Write pulse with Mem_Address=0x04 and data 0xDEADBEEF; Rsp_Valid 2 cycles after accept; Rsp_Rdata=0.
- Byte store 0xA5 to 0x012, memory word 0x04 pre-loaded 0x11223344 -> RD then WR writes 0x11A53344; Rsp_Valid 3 cycles after accept.
- Memory word 0x04 = 0x80F0FF7F: signed byte load at 0x011 -> Rsp_Rdata 0xFFFFFFFF.
- Same word: unsigned byte load at 0x011 -> 0x000000FF.
- Same word: signed half load at 0x012 -> 0xFFFF80F0.
- Halfword load at 0x013 with LSU_STRICT_ALIGN_EN -> Rsp_Error=1, no Mem_Read, Rsp_Valid 1 cycle after accept. Without the macro -> reads the upper half, 0xFFFF80F0 signed.
- Back-to-back: hold Req_Valid high across two loads -> Req_Ready low from RD through RESP; second accept occurs in the IDLE cycle after the first RESP; both results correct.
- Assert rst_n low during the RD cycle of a byte store -> no Mem_Write; memory word unchanged; all outputs at reset values; Req_Ready=1.
